// File: rtl/regfl_reader.sv
// Burst read engine for the 8x64 register file: accepts (addr, len) requests and
// streams one register per beat over a valid/ready output, wrapping modulo N.
module regfl_reader #(
  parameter int W  = 64,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   q,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [AW-1:0]    req_len,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [W-1:0]     rd_data,
  output logic [AW-1:0]    rd_addr,
  output logic             rd_last,
  output logic [15:0]      beat_cnt
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // BURST | streaming beats, requests ignored
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_last_q, rd_last_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [15:0]   beat_cnt_q, beat_cnt_d;

  logic          accept;
  logic          fire;
  logic [AW-1:0] nxt_addr;

  assign accept   = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign fire     = (state_q == ST_BURST) && rd_valid_q && rd_ready;
  assign nxt_addr = rd_addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_addr_d   = rd_addr_q;
    rd_last_d   = rd_last_q;
    rem_d       = rem_q;
    beat_cnt_d  = beat_cnt_q;

    if (accept) begin
      state_d     = ST_BURST;
      req_ready_d = 1'b0;
      rem_d       = req_len;
      rd_addr_d   = req_addr;
      rd_data_d   = q[req_addr*W +: W];
      rd_valid_d  = 1'b1;
      rd_last_d   = (req_len == '0);
    end

    if (fire) begin
      if (beat_cnt_q != 16'hFFFF)
        beat_cnt_d = beat_cnt_q + 16'd1;
      if (rd_last_q) begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
      end else begin
        // rd_addr doubles as the current index; data is captured at launch
        rd_addr_d = nxt_addr;
        rem_d     = rem_q - 1'b1;
        rd_data_d = q[nxt_addr*W +: W];
        rd_last_d = (rem_q == {{(AW-1){1'b0}}, 1'b1});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_last_q   <= 1'b0;
      rem_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_addr_q   <= rd_addr_d;
      rd_last_q   <= rd_last_d;
      rem_q       <= rem_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_last   = rd_last_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_regfl_reader.sv
// Directed bench for regfl_reader: table of burst requests plus hand-written
// sequences for backpressure, busy rejection, reset mid-burst and saturation.
module tb_regfl_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] q;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_addr;
  logic [2:0]   req_len;
  logic         rd_valid;
  logic         rd_ready;
  logic [63:0]  rd_data;
  logic [2:0]   rd_addr;
  logic         rd_last;
  logic [15:0]  beat_cnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_cnt;

  regfl_reader #(.W(64), .N(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .q(q),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_addr(rd_addr), .rd_last(rd_last),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [2:0] len;
    logic [2:0] exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_reg(input int i, input logic [63:0] v);
    q[i*64 +: 64] = v;
  endtask

  task automatic count_beat();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  // Issues a request with rd_ready high and checks every beat of the burst.
  task automatic run_burst(input logic [2:0] a, input logic [2:0] l, input logic [2:0] last_a);
    logic [2:0] ea;
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    rd_ready  = 1'b1;
    tick();
    req_valid = 1'b0;
    ea = a;
    for (int b = 0; b <= int'(l); b++) begin
      check("beat_valid", {63'd0, rd_valid}, 64'd1);
      check("beat_addr", {61'd0, rd_addr}, {61'd0, ea});
      check("beat_data", rd_data, 64'h100 + {61'd0, ea});
      check("beat_last", {63'd0, rd_last}, {63'd0, (b == int'(l))});
      if (b == int'(l)) check("last_addr", {61'd0, rd_addr}, {61'd0, last_a});
      count_beat();
      tick();
      ea = ea + 3'd1;
    end
    check("end_valid", {63'd0, rd_valid}, 64'd0);
    check("end_ready", {63'd0, req_ready}, 64'd1);
    check("end_cnt", {48'd0, beat_cnt}, {48'd0, exp_cnt});
  endtask

  initial begin
    vecs[0] = '{3'd6, 3'd3, 3'd1};
    vecs[1] = '{3'd7, 3'd0, 3'd7};
    vecs[2] = '{3'd5, 3'd7, 3'd4};
    vecs[3] = '{3'd0, 3'd7, 3'd7};
    vecs[4] = '{3'd1, 3'd2, 3'd3};
    vecs[5] = '{3'd4, 3'd1, 3'd5};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_reg(i, 64'h100 + 64'(i));
    exp_cnt = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    check("rst_rd_addr", {61'd0, rd_addr}, 64'd0);
    check("rst_rd_last", {63'd0, rd_last}, 64'd0);

    // single read of a distinctive value
    set_reg(3, 64'hDEAD_BEEF_0000_0003);
    req_addr = 3'd3; req_len = 3'd0; req_valid = 1'b1; rd_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    set_reg(3, 64'h103);
    check("single_valid", {63'd0, rd_valid}, 64'd1);
    check("single_data", rd_data, 64'hDEAD_BEEF_0000_0003);
    check("single_addr", {61'd0, rd_addr}, 64'd3);
    check("single_last", {63'd0, rd_last}, 64'd1);
    check("single_ready_low", {63'd0, req_ready}, 64'd0);
    count_beat();
    tick();
    check("single_done_valid", {63'd0, rd_valid}, 64'd0);
    check("single_done_ready", {63'd0, req_ready}, 64'd1);
    check("single_cnt", {48'd0, beat_cnt}, 64'd1);

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].exp_last_addr);
      tick();
    end

    // backpressure: data captured at launch survives a change to q
    set_reg(0, 64'hAAAA_0000_0000_0000);
    rd_ready = 1'b0;
    req_addr = 3'd0; req_len = 3'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    set_reg(0, 64'hBBBB_0000_0000_0000);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", {63'd0, rd_valid}, 64'd1);
      check("bp_data_hold", rd_data, 64'hAAAA_0000_0000_0000);
      check("bp_addr_hold", {61'd0, rd_addr}, 64'd0);
      check("bp_last_hold", {63'd0, rd_last}, 64'd0);
      tick();
    end
    check("bp_cnt_stall", {48'd0, beat_cnt}, {48'd0, exp_cnt});
    rd_ready = 1'b1;
    tick();
    count_beat();
    check("bp_beat1_valid", {63'd0, rd_valid}, 64'd1);
    check("bp_beat1_addr", {61'd0, rd_addr}, 64'd1);
    check("bp_beat1_data", rd_data, 64'h101);
    check("bp_beat1_last", {63'd0, rd_last}, 64'd1);
    tick();
    count_beat();
    check("bp_done_valid", {63'd0, rd_valid}, 64'd0);
    check("bp_cnt", {48'd0, beat_cnt}, {48'd0, exp_cnt});
    set_reg(0, 64'h100);

    // busy rejection: a held request is taken only after the bubble
    req_addr = 3'd2; req_len = 3'd7; req_valid = 1'b1; rd_ready = 1'b1;
    tick();
    req_addr = 3'd5; req_len = 3'd0;
    for (int b = 0; b < 8; b++) begin
      check("busy_ready_low", {63'd0, req_ready}, 64'd0);
      check("busy_addr", {61'd0, rd_addr}, {61'd0, 3'(b + 2)});
      count_beat();
      tick();
    end
    check("bubble_valid", {63'd0, rd_valid}, 64'd0);
    check("bubble_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    check("second_valid", {63'd0, rd_valid}, 64'd1);
    check("second_addr", {61'd0, rd_addr}, 64'd5);
    check("second_last", {63'd0, rd_last}, 64'd1);
    count_beat();
    tick();
    check("second_cnt", {48'd0, beat_cnt}, {48'd0, exp_cnt});

    // reset mid-burst aborts everything
    req_addr = 3'd0; req_len = 3'd7; req_valid = 1'b1; rd_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("pre_rst_addr", {61'd0, rd_addr}, 64'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    check("midrst_valid", {63'd0, rd_valid}, 64'd0);
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_cnt", {48'd0, beat_cnt}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      check("midrst_no_beat", {63'd0, rd_valid}, 64'd0);
      tick();
    end

    // saturation: continuous 8-beat bursts well past 65535 beats
    req_addr = 3'd0; req_len = 3'd7; req_valid = 1'b1; rd_ready = 1'b1;
    for (int c = 0; c < 74000; c++) @(posedge clk);
    #1;
    check("sat_cnt", {48'd0, beat_cnt}, 64'hFFFF);
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) @(posedge clk);
    #1;
    check("sat_hold", {48'd0, beat_cnt}, 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfl_reader.md
Name: regfl_reader

Overview:
- Read-side engine for the 8x64-bit register file; consumes the register file's flattened 512-bit contents bus.
- Accepts burst read requests (start index + length) over a valid/ready handshake.
- Streams the selected registers one per beat on a valid/ready output with backpressure, wrapping modulo the register count.
- Sits between the register file and any consumer such as a serializer or test monitor.

Parameters:
- W, 64, data width of one register.
- N, 8, number of registers; must be a power of two.
- AW, 3, index width, log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- q  input  N*W (512)  flattened register contents; register i occupies bits [i*W +: W].
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when high together with req_valid.
- req_addr  input  AW  first register index.
- req_len  input  AW  beat count minus 1 (0 = 1 beat, 7 = 8 beats).
- rd_valid  output  1  output beat valid.
- rd_ready  input  1  consumer ready.
- rd_data  output  W  register contents.
- rd_addr  output  AW  index of the register in rd_data.
- rd_last  output  1  final beat of the burst.
- beat_cnt  output  16  total completed output beats; saturating.

Behaviour:
- Reset (rst_n low at a posedge; takes priority over everything):
  - State IDLE, req_ready=1, rd_valid=0, rd_data=0, rd_addr=0, rd_last=0, beat_cnt=0.
  - Reset during a burst aborts it; no partial beats appear afterwards.
- FSM states: IDLE and BURST.
  - req_ready = (state==IDLE), driven from a register.
  - In BURST, req_valid is ignored.
- IDLE -> BURST: at the edge where req_valid && req_ready:
  - cur = req_addr, rem = req_len.
  - rd_data loads q[req_addr*W +: W] sampled at that edge.
  - rd_addr=req_addr, rd_valid=1, rd_last=(req_len==0).
  - Latency: data is visible in the cycle after acceptance.
- BURST, edge with rd_valid && rd_ready:
  - beat_cnt increments, holding at 0xFFFF once reached.
  - If rd_last=1: rd_valid=0, rd_last=0, state goes to IDLE, and req_ready=1 from the next cycle. A new request cannot be accepted in the same cycle as the last handshake, so there is a 1-cycle bubble minimum between bursts.
  - Else: cur=(cur+1) mod N (wrap 7->0), rem=rem-1.
  - Else (continued): rd_data loads q[cur_new*W +: W] sampled at that edge; rd_addr=cur_new; rd_last=(rem_new==0); rd_valid stays 1. This gives back-to-back beats, 1 per cycle.
- Backpressure: while rd_valid && !rd_ready, rd_data, rd_addr and rd_last hold stable even if q changes. Each register's contents are captured when its beat is launched, not when it is consumed.
- rd_data, rd_addr and rd_last are don't-care-free: when rd_valid=0 they keep their last value (0 after reset).
- Index arithmetic is unsigned AW-bit with natural wrap-around. A burst of length 8 reads every register exactly once.
- No combinational path from rd_ready or req_valid to any output.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> req_ready=1, rd_valid=0, rd_data=0, beat_cnt=0.
- Single read: q reg3=64'hDEAD_BEEF_0000_0003, req addr=3 len=0, rd_ready=1 -> next cycle rd_valid=1, rd_data=…0003, rd_addr=3, rd_last=1. After the handshake, rd_valid=0 and req_ready=1. beat_cnt=1.
- Wrapping burst: reg i = i+64'h100, req addr=6 len=3, rd_ready=1 -> 4 consecutive beats:
  - rd_addr 6,7,0,1 with data 0x106,0x107,0x100,0x101.
  - rd_last only on the 4th beat; beat_cnt increases by 4.
- Backpressure: addr=0 len=1, rd_ready=0 for 3 cycles with q reg0 changed mid-stall -> rd_data holds the value captured at acceptance. Then rd_ready=1 -> beat 0 then beat 1, no beat dropped or duplicated.
- Busy rejection: req_valid held high during an 8-beat burst -> req_ready=0 throughout. The second request is accepted only 1 cycle after the last beat's handshake.
- Reset mid-burst: rst_n=0 on beat 2 of an 8-beat burst -> the next cycle shows rd_valid=0, req_ready=1, beat_cnt=0, and no further beats appear.
